bit_converter_feeder: RTL and testbench
=======================================

Name: bit_converter_feeder

Overview:
Sequential front-end for the 4-bit code converter (inputs a,b,c,d; outputs w,x,y,z).
- Assembles a serial bit stream into 4-bit frames and drives the frames onto the converter inputs.
- Holds each frame stable for a settle window, captures the converter's result and offers it downstream on a valid/ready handshake.
- Lets the lab board feed the converter from one serial line instead of four switches.

Parameters:
SETTLE_CYCLES, 1, cycles between loading a,b,c,d and capturing w,x,y,z; legal range 1..15
CNT_W, 8, width of frame_cnt

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ser_in  input  1  serial data bit, first bit is MSB (maps to a)
ser_valid  input  1  ser_in carries a bit this cycle
ser_ready  output  1  block accepts a bit this cycle
a  output  1  converter input, frame bit 3 (MSB)
b  output  1  converter input, frame bit 2
c  output  1  converter input, frame bit 1
d  output  1  converter input, frame bit 0 (LSB)
w  input  1  converter output bit 3
x  input  1  converter output bit 2
y  input  1  converter output bit 1
z  input  1  converter output bit 0
out_data  output  4  captured {w,x,y,z}
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts out_data
clr_overrun  input  1  synchronous clear of the overrun flag
overrun  output  1  sticky flag: a bit was offered while ser_ready was 0
frame_cnt  output  CNT_W  count of completed output handshakes, wraps

Behaviour:
Reset (rst_n low, asynchronous):
- State goes to COLLECT.
- Bit counter, shift register, the a/b/c/d hold register, out_data, out_valid, overrun and frame_cnt all clear to 0.
- ser_ready = 1 while in COLLECT, including during reset.
- Reset mid-frame discards the partial bits and any pending output with no handshake.

State COLLECT:
- ser_ready = 1.
- A bit is accepted on a rising edge with ser_valid=1; it shifts into the shift register and the bit counter increments.
- On the 4th accepted bit, the same edge loads the hold register with all 4 bits, resets the bit counter to 0 and moves to SETTLE. The settle counter loads SETTLE_CYCLES-1.
- a,b,c,d come only from the hold register, so they change once per frame and never during shifting.
- Bit order: 1st accepted bit goes to a, 2nd to b, 3rd to c, 4th to d.

State SETTLE:
- ser_ready = 0.
- The settle counter decrements each edge.
- On the edge where the counter reads 0: out_data <= {w,x,y,z}, out_valid <= 1, move to OUTPUT.
- Timing with SETTLE_CYCLES=1: 4th bit accepted at edge N; a..d new after N; capture at N+1; out_valid high after N+1.
- General latency: out_valid rises SETTLE_CYCLES edges after the 4th-bit edge.

State OUTPUT:
- ser_ready = 0; out_valid = 1; out_data held stable.
- On an edge with out_ready=1: out_valid <= 0, frame_cnt <= frame_cnt+1 (wraps modulo 2^CNT_W), move to COLLECT.
- A new frame can begin on the cycle after the handshake.
- out_ready is ignored in every other state.
- a,b,c,d keep the last frame until the next 4th-bit edge.

Overrun:
- Any edge with ser_valid=1 and ser_ready=0 sets overrun to 1; the bit is dropped.
- overrun stays set until clr_overrun=1 on an edge or reset.
- If set and clear occur on the same edge, set wins.

Other rules:
- out_data and frame_cnt are registered; no combinational path from ser_in to any output.
- ser_ready is a pure state decode.

Test Plan:
- Bench ties {w,x,y,z} = ~{a,b,c,d}. Reset, then serial 1,0,1,1 with ser_valid every cycle and out_ready=1 -> a..d=1011 after the 4th edge; out_valid high exactly 1 edge later; out_data=4'b0100; frame_cnt=1.
- Back-to-back frames 0000, 1111, 0110 with out_ready=1 -> out_data 1111, 0000, 1001 in order; frame_cnt=3; overrun=0.
- out_ready held 0 for 5 cycles after out_valid, with ser_valid pulsed during that window -> out_data stable; ser_ready=0; overrun=1. Then clr_overrun pulse -> overrun=0. Then out_ready=1 -> one handshake.
- SETTLE_CYCLES=4, frame 1001 -> out_valid rises 4 edges after the 4th-bit edge; out_data=0110.
- Assert rst_n low after 2 of 4 bits, release, send 0011 -> first output is 1100 (partial bits discarded); frame_cnt=1.
- CNT_W=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/bit_converter_feeder.sv
// ---------------------------------------------------------------------------
// bit_converter_feeder
//
// Sequential front-end for a 4-bit combinational code converter. A serial bit
// stream (MSB first) is assembled into 4-bit frames. Each frame is held on the
// converter inputs a,b,c,d for a settle window. The converter result w,x,y,z
// is then captured and offered downstream on a valid/ready handshake.
//
// Parameters
//   SETTLE_CYCLES  edges between loading a..d and capturing w..z (1..15)
//   CNT_W          width of frame_cnt
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   ser_in, ser_valid   serial bit and its qualifier
//   ser_ready           high while collecting bits (pure state decode)
//   a, b, c, d          converter inputs, frame bits 3..0, from hold register
//   w, x, y, z          converter outputs, bits 3..0
//   out_data/valid/ready  captured {w,x,y,z} with handshake
//   clr_overrun         synchronous clear of overrun
//   overrun             sticky: a bit was offered while ser_ready was low
//   frame_cnt           completed output handshakes, wraps
// ---------------------------------------------------------------------------
module bit_converter_feeder #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             w,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic [3:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETTLE  = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e           state_q,     state_d;
  logic [1:0]       bit_cnt_q,   bit_cnt_d;
  // Only the first three bits need storing; the fourth goes straight into
  // the hold register on the edge that completes the frame.
  logic [2:0]       shift_q,     shift_d;
  logic [3:0]       hold_q,      hold_d;
  logic [3:0]       settle_q,    settle_d;
  logic [3:0]       out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q,   overrun_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign ser_ready = (state_q == COLLECT);

  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    settle_d    = settle_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      COLLECT: begin
        if (ser_valid) begin
          if (bit_cnt_q == 2'd3) begin
            hold_d    = {shift_q, ser_in};
            bit_cnt_d = 2'd0;
            settle_d  = SETTLE_LOAD;
            state_d   = SETTLE;
          end else begin
            shift_d   = {shift_q[1:0], ser_in};
            bit_cnt_d = bit_cnt_q + 2'd1;
          end
        end
      end
      SETTLE: begin
        if (settle_q == 4'd0) begin
          out_data_d  = {w, x, y, z};
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Set has priority over clear so an overrun on the clearing edge is kept.
  always_comb begin
    overrun_d = overrun_q;
    if (ser_valid && !ser_ready) overrun_d = 1'b1;
    else if (clr_overrun)        overrun_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      settle_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      settle_q    <= settle_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign {a, b, c, d} = hold_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign overrun      = overrun_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_bit_converter_feeder.sv
// ---------------------------------------------------------------------------
// tb_bit_converter_feeder
//
// Three instances share clock, reset, ser_in, out_ready and clr_overrun; each
// has its own ser_valid so only the instance under test sees traffic:
//   u0 defaults, u1 SETTLE_CYCLES=4, u2 CNT_W=2.
// Each converter is modelled as {w,x,y,z} = ~{a,b,c,d}. Expected outputs are
// queued when a frame is sent and popped by a monitor on each handshake.
// ---------------------------------------------------------------------------
module tb_bit_converter_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_in = 1'b0;
  logic [2:0] ser_valid = 3'b000;
  logic       out_ready = 1'b0;
  logic       clr_overrun = 1'b0;

  logic [2:0] ser_ready, out_valid, overrun;
  logic [3:0] abcd [3];
  logic [3:0] wxyz [3];
  logic [3:0] out_data [3];
  logic [7:0] fc [3];
  logic [7:0] fc0, fc1;
  logic [1:0] fc2;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_conv
    assign wxyz[g] = ~abcd[g];
  end
  assign fc[0] = fc0;
  assign fc[1] = fc1;
  assign fc[2] = {6'd0, fc2};

  bit_converter_feeder u0 (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid[0]),
    .ser_ready(ser_ready[0]),
    .a(abcd[0][3]), .b(abcd[0][2]), .c(abcd[0][1]), .d(abcd[0][0]),
    .w(wxyz[0][3]), .x(wxyz[0][2]), .y(wxyz[0][1]), .z(wxyz[0][0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .clr_overrun(clr_overrun), .overrun(overrun[0]), .frame_cnt(fc0)
  );

  bit_converter_feeder #(.SETTLE_CYCLES(4)) u1 (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid[1]),
    .ser_ready(ser_ready[1]),
    .a(abcd[1][3]), .b(abcd[1][2]), .c(abcd[1][1]), .d(abcd[1][0]),
    .w(wxyz[1][3]), .x(wxyz[1][2]), .y(wxyz[1][1]), .z(wxyz[1][0]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .clr_overrun(clr_overrun), .overrun(overrun[1]), .frame_cnt(fc1)
  );

  bit_converter_feeder #(.CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid[2]),
    .ser_ready(ser_ready[2]),
    .a(abcd[2][3]), .b(abcd[2][2]), .c(abcd[2][1]), .d(abcd[2][0]),
    .w(wxyz[2][3]), .x(wxyz[2][2]), .y(wxyz[2][1]), .z(wxyz[2][0]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready),
    .clr_overrun(clr_overrun), .overrun(overrun[2]), .frame_cnt(fc2)
  );

  typedef struct {
    int         inst;
    logic [3:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   fc_model [3];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Handshake monitor: inputs change 1 time unit after posedge, so the values
  // seen at negedge are the ones the next posedge will act on.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n && out_valid[i] && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {4'd0, out_data[i]}, 8'hff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_inst", 8'(i), 8'(e.inst));
          check("out_data", {4'd0, out_data[i]}, {4'd0, e.data});
          check("frame_cnt_pre", fc[i], 8'(fc_model[i]));
          fc_model[i] = (fc_model[i] + 1) % ((i == 2) ? 4 : 256);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ser_valid = 3'b000;
    clr_overrun = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) fc_model[i] = 0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input int sel);
    int n = 0;
    while (!(ser_ready[sel] && !out_valid[sel]) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("wait_ready_timeout", 8'(n), 8'd0);
  endtask

  // Sends four bits MSB first on consecutive edges and queues the converter
  // result the bench expects for them.
  task automatic send_frame(input int sel, input logic [3:0] bits);
    exp_t e;
    wait_ready(sel);
    e.inst = sel;
    e.data = ~bits;
    exp_q.push_back(e);
    for (int i = 3; i >= 0; i--) begin
      ser_in = bits[i];
      ser_valid[sel] = 1'b1;
      tick();
    end
    ser_valid[sel] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid != 3'b000) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("drain_timeout", 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    logic [3:0] pat [3];
    int k;

    // Reset state, sampled while rst_n is still low.
    #2;
    check("rst_ser_ready", {5'd0, ser_ready}, 8'h07);
    check("rst_out_valid", {5'd0, out_valid}, 8'h00);
    check("rst_overrun",   {5'd0, overrun},   8'h00);
    check("rst_abcd",      {4'd0, abcd[0]},   8'h00);
    check("rst_frame_cnt", fc[0],             8'h00);
    do_reset();

    // First frame, SETTLE_CYCLES=1 latency.
    out_ready = 1'b1;
    send_frame(0, 4'b1011);
    check("t1_abcd", {4'd0, abcd[0]}, 8'h0b);
    check("t1_valid_early", {7'd0, out_valid[0]}, 8'h00);
    tick();
    check("t1_valid", {7'd0, out_valid[0]}, 8'h01);
    check("t1_data", {4'd0, out_data[0]}, 8'h04);
    tick();
    check("t1_frame_cnt", fc[0], 8'd1);
    check("t1_valid_low", {7'd0, out_valid[0]}, 8'h00);

    // Back-to-back frames.
    do_reset();
    pat[0] = 4'b0000; pat[1] = 4'b1111; pat[2] = 4'b0110;
    for (int i = 0; i < 3; i++) send_frame(0, pat[i]);
    drain();
    check("t2_frame_cnt", fc[0], 8'd3);
    check("t2_overrun", {7'd0, overrun[0]}, 8'h00);

    // Backpressure, overrun set/clear priority, then a single handshake.
    out_ready = 1'b0;
    send_frame(0, 4'b1100);
    k = 0;
    while (!out_valid[0] && k < 20) begin tick(); k++; end
    check("t3_valid_seen", {7'd0, out_valid[0]}, 8'h01);
    for (int i = 0; i < 5; i++) begin
      ser_valid[0] = (i == 1 || i == 3);
      tick();
      check("t3_data_stable", {4'd0, out_data[0]}, 8'h03);
      check("t3_ser_ready", {7'd0, ser_ready[0]}, 8'h00);
    end
    ser_valid[0] = 1'b0;
    check("t3_overrun_set", {7'd0, overrun[0]}, 8'h01);
    ser_valid[0] = 1'b1;
    clr_overrun = 1'b1;
    tick();
    ser_valid[0] = 1'b0;
    check("t3_set_wins", {7'd0, overrun[0]}, 8'h01);
    tick();
    clr_overrun = 1'b0;
    check("t3_overrun_clr", {7'd0, overrun[0]}, 8'h00);
    out_ready = 1'b1;
    tick();
    check("t3_valid_low", {7'd0, out_valid[0]}, 8'h00);
    check("t3_frame_cnt", fc[0], 8'd4);
    check("t3_queue_empty", 8'(exp_q.size()), 8'd0);

    // SETTLE_CYCLES=4 latency.
    send_frame(1, 4'b1001);
    k = 0;
    while (!out_valid[1] && k < 20) begin tick(); k++; end
    check("t4_latency", 8'(k), 8'd4);
    check("t4_data", {4'd0, out_data[1]}, 8'h06);
    drain();

    // Reset mid-frame discards partial bits.
    wait_ready(0);
    for (int i = 0; i < 2; i++) begin
      ser_in = 1'b1;
      ser_valid[0] = 1'b1;
      tick();
    end
    do_reset();
    send_frame(0, 4'b0011);
    drain();
    check("t5_frame_cnt", fc[0], 8'd1);

    // CNT_W=2 wrap.
    for (int i = 0; i < 5; i++) begin
      send_frame(2, 4'(i + 5));
      drain();
      check("t6_frame_cnt", fc[2], 8'((i + 1) % 4));
    end

    check("end_queue_empty", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
